rx_wr_mem_eng: RTL and testbench

Receive-side payload write engine, the counterpart of the TX read-memory engine: it takes a per-flow write request (flow ID, buffer offset, byte count) plus a MAC-width payload stream, and writes the payload into the flow's DRAM buffer as one NoC0 store message. It then waits for the DRAM store acknowledgement and reports completion per request. It sits between the RX MAC-side datapath and the NoC0 val/rdy-to-credit adapters of its tile.

---
 rtl/rx_wr_mem_eng.sv | 251 +++++++++++++++++++++++++
 tb/tb_rx_wr_mem_eng.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_wr_mem_eng.sv
// rx_wr_mem_eng
//
// Receive-side payload write engine. It accepts one write request at a time
// (flow ID, buffer offset, byte count) and writes the matching MAC-width
// payload stream into the flow's DRAM buffer as a single NoC0 store message:
// one header flit followed by ceil(size/B) data flits. It then waits for the
// DRAM store acknowledgement and reports completion for the request.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   src_wr_mem_rx_req_*            write request (val/flowid/offset/size), rdy out
//   src_wr_mem_rx_data_*           payload stream (val/data/last/padbytes), rdy out
//   wr_mem_noc0_val/_data          flits toward the NoC0 val/rdy-to-credit adapter
//   noc0_wr_mem_rdy                that adapter's ready
//   noc0_wr_mem_val/_data          flits from the NoC0 credit-to-val/rdy adapter
//   wr_mem_noc0_rdy                ready back to that adapter
//   wr_mem_dst_rx_done_*           completion (val/flowid), rdy in
//   wr_mem_len_err                 one-cycle pulse on a stream length/padbytes mismatch
module rx_wr_mem_eng #(
  parameter int XY_WIDTH              = 8,
  parameter int FLOW_ID_W             = 8,
  parameter int PAYLOAD_PTR_W         = 20,
  parameter int MSG_DATA_SIZE_WIDTH   = 16,
  parameter int MAC_INTERFACE_W       = 512,
  parameter int MAC_PADBYTES_W        = 6,
  parameter int NOC_DATA_WIDTH        = 512,
  parameter int MSG_LENGTH_WIDTH      = 8,
  parameter int MSG_TYPE_WIDTH        = 8,
  parameter int MSG_ADDR_WIDTH        = 40,
  parameter int MSG_TYPE_STORE_MEM    = 2,
  parameter int MSG_TYPE_STORE_MEM_ACK = 3,
  parameter int SRC_X                 = 0,
  parameter int SRC_Y                 = 0,
  parameter int DST_DRAM_X            = 0,
  parameter int DST_DRAM_Y            = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,

  input  logic                           src_wr_mem_rx_req_val,
  input  logic [FLOW_ID_W-1:0]           src_wr_mem_rx_req_flowid,
  input  logic [PAYLOAD_PTR_W-1:0]       src_wr_mem_rx_req_offset,
  input  logic [MSG_DATA_SIZE_WIDTH-1:0] src_wr_mem_rx_req_size,
  output logic                           wr_mem_src_rx_req_rdy,

  input  logic                           src_wr_mem_rx_data_val,
  input  logic [MAC_INTERFACE_W-1:0]     src_wr_mem_rx_data,
  input  logic                           src_wr_mem_rx_data_last,
  input  logic [MAC_PADBYTES_W-1:0]      src_wr_mem_rx_data_padbytes,
  output logic                           wr_mem_src_rx_data_rdy,

  output logic                           wr_mem_noc0_val,
  output logic [NOC_DATA_WIDTH-1:0]      wr_mem_noc0_data,
  input  logic                           noc0_wr_mem_rdy,

  input  logic                           noc0_wr_mem_val,
  input  logic [NOC_DATA_WIDTH-1:0]      noc0_wr_mem_data,
  output logic                           wr_mem_noc0_rdy,

  output logic                           wr_mem_dst_rx_done_val,
  output logic [FLOW_ID_W-1:0]           wr_mem_dst_rx_done_flowid,
  input  logic                           dst_wr_mem_rx_done_rdy,

  output logic                           wr_mem_len_err
);

  localparam int BYTES = NOC_DATA_WIDTH / 8;
  localparam int BSH   = $clog2(BYTES);
  localparam int CNT_W = MSG_DATA_SIZE_WIDTH - BSH + 1;

  // Header field positions, packed MSB-first from the top of the flit.
  localparam int TOP      = NOC_DATA_WIDTH - 1;
  localparam int POS_DX   = TOP;
  localparam int POS_DY   = TOP - XY_WIDTH;
  localparam int POS_SX   = TOP - 2 * XY_WIDTH;
  localparam int POS_SY   = TOP - 3 * XY_WIDTH;
  localparam int POS_LEN  = TOP - 4 * XY_WIDTH;
  localparam int POS_TYPE = POS_LEN - MSG_LENGTH_WIDTH;
  localparam int POS_ADDR = POS_TYPE - MSG_TYPE_WIDTH;
  localparam int POS_SIZE = POS_ADDR - MSG_ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    ZFILL,
    DRAIN,
    WAIT_ACK,
    DONE
  } state_e;

  state_e                         state_q, state_d;
  logic [FLOW_ID_W-1:0]           flowId_q, flowId_d;
  logic [MSG_ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [MSG_DATA_SIZE_WIDTH-1:0] size_q, size_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [MAC_PADBYTES_W-1:0]      expPad_q, expPad_d;

  logic [MSG_DATA_SIZE_WIDTH:0]   sizeRoundUp;
  logic [CNT_W-1:0]               beatsCalc;
  logic [MSG_DATA_SIZE_WIDTH-1:0] negSize;
  logic [MAC_PADBYTES_W-1:0]      expPadCalc;
  logic [NOC_DATA_WIDTH-1:0]      header;
  logic                           ackSeen;
  logic                           unusedAckBits;

  // Beat count is ceil(size/B); the expected pad of the last beat is the
  // distance to the next flit boundary, i.e. (-size) mod B.
  assign sizeRoundUp = {1'b0, src_wr_mem_rx_req_size} + (MSG_DATA_SIZE_WIDTH + 1)'(BYTES - 1);
  assign beatsCalc   = sizeRoundUp[MSG_DATA_SIZE_WIDTH:BSH];
  assign negSize     = -src_wr_mem_rx_req_size;
  assign expPadCalc  = MAC_PADBYTES_W'(negSize[BSH-1:0]);

  assign ackSeen       = noc0_wr_mem_data[POS_TYPE -: MSG_TYPE_WIDTH] == MSG_TYPE_WIDTH'(MSG_TYPE_STORE_MEM_ACK);
  assign unusedAckBits = ^noc0_wr_mem_data;

  assign wr_mem_dst_rx_done_flowid = flowId_q;

  // Header flit built from latched request state. The beat counter still
  // holds the full beat count while the header is on the wire, so it doubles
  // as msg_len.
  always_comb begin
    header = '0;
    header[POS_DX -: XY_WIDTH]           = XY_WIDTH'(DST_DRAM_X);
    header[POS_DY -: XY_WIDTH]           = XY_WIDTH'(DST_DRAM_Y);
    header[POS_SX -: XY_WIDTH]           = XY_WIDTH'(SRC_X);
    header[POS_SY -: XY_WIDTH]           = XY_WIDTH'(SRC_Y);
    header[POS_LEN -: MSG_LENGTH_WIDTH]  = MSG_LENGTH_WIDTH'(cnt_q);
    header[POS_TYPE -: MSG_TYPE_WIDTH]   = MSG_TYPE_WIDTH'(MSG_TYPE_STORE_MEM);
    header[POS_ADDR -: MSG_ADDR_WIDTH]   = addr_q;
    header[POS_SIZE -: MSG_DATA_SIZE_WIDTH] = size_q;
  end

  // State and request latches. Reset aborts any message in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      flowId_q <= '0;
      addr_q   <= '0;
      size_q   <= '0;
      cnt_q    <= '0;
      expPad_q <= '0;
    end else begin
      state_q  <= state_d;
      flowId_q <= flowId_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      cnt_q    <= cnt_d;
      expPad_q <= expPad_d;
    end
  end

  // Next-state and output decode. In DATA the payload passes straight through
  // to NoC0; a short stream is padded out with zero flits (ZFILL) and a long
  // one has its excess beats discarded (DRAIN), so the NoC message always has
  // the length announced in the header.
  always_comb begin
    state_d  = state_q;
    flowId_d = flowId_q;
    addr_d   = addr_q;
    size_d   = size_q;
    cnt_d    = cnt_q;
    expPad_d = expPad_q;

    wr_mem_src_rx_req_rdy  = 1'b0;
    wr_mem_src_rx_data_rdy = 1'b0;
    wr_mem_noc0_val        = 1'b0;
    wr_mem_noc0_data       = '0;
    wr_mem_noc0_rdy        = 1'b0;
    wr_mem_dst_rx_done_val = 1'b0;
    wr_mem_len_err         = 1'b0;

    case (state_q)
      IDLE: begin
        wr_mem_src_rx_req_rdy = 1'b1;
        if (src_wr_mem_rx_req_val) begin
          flowId_d = src_wr_mem_rx_req_flowid;
          addr_d   = MSG_ADDR_WIDTH'({src_wr_mem_rx_req_flowid, src_wr_mem_rx_req_offset});
          size_d   = src_wr_mem_rx_req_size;
          cnt_d    = beatsCalc;
          expPad_d = expPadCalc;
          state_d  = (src_wr_mem_rx_req_size == '0) ? DONE : HDR;
        end
      end

      HDR: begin
        wr_mem_noc0_val  = 1'b1;
        wr_mem_noc0_data = header;
        if (noc0_wr_mem_rdy) begin
          state_d = DATA;
        end
      end

      DATA: begin
        wr_mem_noc0_val        = src_wr_mem_rx_data_val;
        wr_mem_noc0_data       = NOC_DATA_WIDTH'(src_wr_mem_rx_data);
        wr_mem_src_rx_data_rdy = noc0_wr_mem_rdy;
        if (src_wr_mem_rx_data_val && noc0_wr_mem_rdy) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            if (src_wr_mem_rx_data_last && (src_wr_mem_rx_data_padbytes == expPad_q)) begin
              state_d = WAIT_ACK;
            end else begin
              wr_mem_len_err = 1'b1;
              state_d        = src_wr_mem_rx_data_last ? WAIT_ACK : DRAIN;
            end
          end else if (src_wr_mem_rx_data_last) begin
            wr_mem_len_err = 1'b1;
            state_d        = ZFILL;
          end
        end
      end

      ZFILL: begin
        wr_mem_noc0_val = 1'b1;
        if (noc0_wr_mem_rdy) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = WAIT_ACK;
          end
        end
      end

      DRAIN: begin
        wr_mem_src_rx_data_rdy = 1'b1;
        if (src_wr_mem_rx_data_val && src_wr_mem_rx_data_last) begin
          state_d = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        wr_mem_noc0_rdy = 1'b1;
        if (noc0_wr_mem_val && ackSeen) begin
          state_d = DONE;
        end
      end

      DONE: begin
        wr_mem_dst_rx_done_val = 1'b1;
        if (dst_wr_mem_rx_done_rdy) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rx_wr_mem_eng.sv
// tb_rx_wr_mem_eng
//
// Self-checking bench for rx_wr_mem_eng. A table of request scenarios with
// hand-computed expectations is driven cycle by cycle; NoC flits, consumed
// payload beats, len_err pulses and completion timing are collected and
// compared. A hand-written sequence covers reset in the middle of DATA.
module tb_rx_wr_mem_eng;

  localparam logic [7:0] SRC_X  = 8'd1;
  localparam logic [7:0] SRC_Y  = 8'd2;
  localparam logic [7:0] DST_X  = 8'd5;
  localparam logic [7:0] DST_Y  = 8'd6;
  localparam logic [7:0] T_STORE = 8'h02;
  localparam logic [7:0] T_ACK   = 8'h03;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         reqVal = 1'b0;
  logic [7:0]   reqFlow = '0;
  logic [19:0]  reqOff = '0;
  logic [15:0]  reqSize = '0;
  logic         reqRdy;
  logic         rxVal = 1'b0;
  logic [511:0] rxData = '0;
  logic         rxLast = 1'b0;
  logic [5:0]   rxPad = '0;
  logic         rxRdy;
  logic         nocOutVal;
  logic [511:0] nocOutData;
  logic         nocOutRdy = 1'b1;
  logic         nocInVal = 1'b0;
  logic [511:0] nocInData = '0;
  logic         nocInRdy;
  logic         doneVal;
  logic [7:0]   doneFlow;
  logic         doneRdy = 1'b1;
  logic         lenErr;

  int nChecks = 0;
  int nFails = 0;

  rx_wr_mem_eng #(
    .SRC_X(1), .SRC_Y(2), .DST_DRAM_X(5), .DST_DRAM_Y(6)
  ) dut (
    .clk                         (clk),
    .rst_n                       (rst_n),
    .src_wr_mem_rx_req_val       (reqVal),
    .src_wr_mem_rx_req_flowid    (reqFlow),
    .src_wr_mem_rx_req_offset    (reqOff),
    .src_wr_mem_rx_req_size      (reqSize),
    .wr_mem_src_rx_req_rdy       (reqRdy),
    .src_wr_mem_rx_data_val      (rxVal),
    .src_wr_mem_rx_data          (rxData),
    .src_wr_mem_rx_data_last     (rxLast),
    .src_wr_mem_rx_data_padbytes (rxPad),
    .wr_mem_src_rx_data_rdy      (rxRdy),
    .wr_mem_noc0_val             (nocOutVal),
    .wr_mem_noc0_data            (nocOutData),
    .noc0_wr_mem_rdy             (nocOutRdy),
    .noc0_wr_mem_val             (nocInVal),
    .noc0_wr_mem_data            (nocInData),
    .wr_mem_noc0_rdy             (nocInRdy),
    .wr_mem_dst_rx_done_val      (doneVal),
    .wr_mem_dst_rx_done_flowid   (doneFlow),
    .dst_wr_mem_rx_done_rdy      (doneRdy),
    .wr_mem_len_err              (lenErr)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  flow;
    logic [19:0] off;
    logic [15:0] size;
    int          streamBeats;
    int          lastIdx;
    logic [5:0]  padLast;
    bit          toggleRdy;
    bit          junk;
    logic [7:0]  expLen;
    int          expFwd;
    int          expZero;
    int          expErr;
    int          expConsumed;
  } vec_t;

  vec_t vecs[7];

  // Compares one observed value against its expectation and tallies the result.
  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] beatData(input logic [7:0] flow, input int k);
    logic [31:0] w;
    w = {flow, 8'(k), 16'hBEEF};
    return {16{w}};
  endfunction

  function automatic logic [511:0] mkFlit(input logic [7:0] len, input logic [7:0] typ,
                                          input logic [7:0] flow, input logic [19:0] off,
                                          input logic [15:0] size);
    logic [511:0] h;
    h = '0;
    h[511 -: 8] = DST_X;
    h[503 -: 8] = DST_Y;
    h[495 -: 8] = SRC_X;
    h[487 -: 8] = SRC_Y;
    h[479 -: 8] = len;
    h[471 -: 8] = typ;
    h[463 -: 40] = {12'h000, flow, off};
    h[423 -: 16] = size;
    return h;
  endfunction

  task automatic driveStream(input vec_t v, input int sIdx);
    if (sIdx < v.streamBeats) begin
      rxVal  = 1'b1;
      rxData = beatData(v.flow, sIdx);
      rxLast = (sIdx == v.lastIdx);
      rxPad  = (sIdx == v.lastIdx) ? v.padLast : 6'd0;
    end else begin
      rxVal  = 1'b0;
      rxData = '0;
      rxLast = 1'b0;
      rxPad  = '0;
    end
  endtask

  // Runs one request end to end, sampling on the falling edge and updating
  // inputs just after the rising edge, then checks everything collected.
  task automatic applyStimulus(input vec_t v, input int vi);
    logic [511:0] flits[$];
    logic [511:0] expFlit;
    logic [511:0] prevData;
    int consumed = 0, errCnt = 0, acceptIt = -1, firstNocIt = -1;
    int ackIt = -1, doneFirstIt = -1, doneIt = -1, sIdx = 0, expCount;
    bit junkPend, ackPend, prevStall, finished;
    string tag;
    junkPend = v.junk;
    ackPend = 1'b1;
    prevStall = 1'b0;
    finished = 1'b0;
    prevData = '0;
    tag = $sformatf("v%0d", vi);

    reqVal = 1'b1;
    reqFlow = v.flow;
    reqOff = v.off;
    reqSize = v.size;
    driveStream(v, sIdx);
    nocOutRdy = 1'b1;
    doneRdy = 1'b1;
    nocInVal = 1'b1;
    nocInData = junkPend ? mkFlit(8'd1, T_STORE, 8'hEE, 20'h0, 16'd0) : mkFlit(8'd1, T_ACK, 8'h0, 20'h0, 16'd0);

    for (int it = 0; it < 300 && !finished; it++) begin
      @(negedge clk);
      if (doneIt >= 0) begin
        checkOutput({tag, " reqRdyAfterDone"}, 512'(reqRdy), 512'(1));
        checkOutput({tag, " doneValDropped"}, 512'(doneVal), 512'(0));
        finished = 1'b1;
      end
      if (reqVal && reqRdy) acceptIt = it;
      if (prevStall) begin
        checkOutput({tag, " stallValHeld"}, 512'(nocOutVal), 512'(1));
        checkOutput({tag, " stallDataHeld"}, nocOutData, prevData);
      end
      prevStall = nocOutVal && !nocOutRdy;
      prevData = nocOutData;
      if (nocOutVal) begin
        if (firstNocIt < 0) firstNocIt = it;
        if (nocOutRdy) flits.push_back(nocOutData);
      end
      if (rxVal && rxRdy) begin
        consumed++;
        sIdx++;
      end
      if (lenErr) errCnt++;
      if (nocInVal && nocInRdy) begin
        if (junkPend) junkPend = 1'b0;
        else begin
          ackPend = 1'b0;
          ackIt = it;
        end
      end
      if (doneVal && doneFirstIt < 0) doneFirstIt = it;
      if (doneVal && doneRdy && doneIt < 0) begin
        checkOutput({tag, " doneFlowid"}, 512'(doneFlow), 512'(v.flow));
        doneIt = it;
      end
      @(posedge clk);
      #1;
      reqVal = 1'b0;
      driveStream(v, sIdx);
      nocOutRdy = v.toggleRdy ? ((it + 1) % 2 == 0) : 1'b1;
      nocInVal = ackPend;
      nocInData = junkPend ? mkFlit(8'd1, T_STORE, 8'hEE, 20'h0, 16'd0) : mkFlit(8'd1, T_ACK, 8'h0, 20'h0, 16'd0);
    end
    if (!finished) checkOutput({tag, " timeout"}, 512'(0), 512'(1));

    nocInVal = 1'b0;
    nocInData = '0;
    nocOutRdy = 1'b1;
    rxVal = 1'b0;

    expCount = (v.size == 0) ? 0 : 1 + v.expFwd + v.expZero;
    checkOutput({tag, " flitCount"}, 512'(flits.size()), 512'(expCount));
    for (int i = 0; i < flits.size() && i < expCount; i++) begin
      if (i == 0) expFlit = mkFlit(v.expLen, T_STORE, v.flow, v.off, v.size);
      else if (i <= v.expFwd) expFlit = beatData(v.flow, i - 1);
      else expFlit = '0;
      checkOutput($sformatf("%s flit%0d", tag, i), flits[i], expFlit);
    end
    checkOutput({tag, " consumed"}, 512'(consumed), 512'(v.expConsumed));
    checkOutput({tag, " lenErrCount"}, 512'(errCnt), 512'(v.expErr));
    checkOutput({tag, " acceptCycle"}, 512'(acceptIt), 512'(0));
    if (v.size == 0) begin
      checkOutput({tag, " doneLatency"}, 512'(doneFirstIt), 512'(acceptIt + 1));
    end else begin
      checkOutput({tag, " hdrLatency"}, 512'(firstNocIt), 512'(acceptIt + 1));
      checkOutput({tag, " ackToDone"}, 512'(doneFirstIt), 512'(ackIt + 1));
    end
  endtask

  initial begin
    // flow  off      size  sBeats last pad  tog junk len fwd zero err cons
    vecs[0] = '{8'd3, 20'h40,  16'd100, 2, 1, 6'd28, 1'b0, 1'b0, 8'd2, 2, 0, 0, 2};
    vecs[1] = '{8'd5, 20'h100, 16'd64,  1, 0, 6'd0,  1'b1, 1'b0, 8'd1, 1, 0, 0, 1};
    vecs[2] = '{8'd7, 20'h200, 16'd0,   0, 0, 6'd0,  1'b0, 1'b0, 8'd0, 0, 0, 0, 0};
    vecs[3] = '{8'd1, 20'h0,   16'd192, 2, 1, 6'd0,  1'b0, 1'b0, 8'd3, 2, 1, 1, 2};
    vecs[4] = '{8'd2, 20'h80,  16'd64,  3, 2, 6'd0,  1'b0, 1'b0, 8'd1, 1, 0, 1, 3};
    vecs[5] = '{8'd4, 20'h1C0, 16'd100, 2, 1, 6'd27, 1'b0, 1'b0, 8'd2, 2, 0, 1, 2};
    vecs[6] = '{8'd6, 20'h3000,16'd128, 2, 1, 6'd0,  1'b0, 1'b1, 8'd2, 2, 0, 0, 2};

    #12;
    checkOutput("reset reqRdy", 512'(reqRdy), 512'(1));
    checkOutput("reset nocOutVal", 512'(nocOutVal), 512'(0));
    checkOutput("reset rxRdy", 512'(rxRdy), 512'(0));
    checkOutput("reset nocInRdy", 512'(nocInRdy), 512'(0));
    checkOutput("reset doneVal", 512'(doneVal), 512'(0));
    checkOutput("reset lenErr", 512'(lenErr), 512'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Reset asserted while payload is streaming through DATA.
    reqVal = 1'b1;
    reqFlow = 8'd9;
    reqOff = 20'h0;
    reqSize = 16'd192;
    rxVal = 1'b1;
    rxData = beatData(8'd9, 0);
    rxLast = 1'b0;
    rxPad = '0;
    nocOutRdy = 1'b1;
    @(negedge clk);
    checkOutput("rst accept", 512'(reqRdy), 512'(1));
    @(posedge clk);
    #1;
    reqVal = 1'b0;
    @(negedge clk);
    checkOutput("rst header", nocOutData, mkFlit(8'd3, T_STORE, 8'd9, 20'h0, 16'd192));
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rst passthrough", nocOutData, beatData(8'd9, 0));
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst mid nocOutVal", 512'(nocOutVal), 512'(0));
    checkOutput("rst mid reqRdy", 512'(reqRdy), 512'(1));
    checkOutput("rst mid rxRdy", 512'(rxRdy), 512'(0));
    checkOutput("rst mid doneVal", 512'(doneVal), 512'(0));
    rxVal = 1'b0;
    rxData = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(vecs[0], 7);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
